train_data_arbiter: RTL

Parametrised successor to the two-way training-data selector: it arbitrates among `channels` sample sources, each carrying a data vector and a predict vector, with valid/ready handshakes. The granted sample passes through a single registered output stage, and element 0 of the data vector is optionally replaced by the bias constant `gdo_one`. It sits between the sample sources (fresh input, replay/old-sample stores) and the training datapath, and adds round-robin or priority arbitration, back-pressure and a transfer counter.

---
 rtl/train_data_arbiter_pkg.sv | 15 +
 rtl/train_data_arbiter_rr_arbiter.sv | 58 +++++
 rtl/train_data_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/train_data_arbiter_pkg.sv
// Shared constants and types for the training-data arbiter.
// Holds the bias constant and the arbitration mode encoding.
package gdo;

    // Bias element injected into data element 0 (1.0 in Q8.8).
    localparam logic [15:0] gdo_one = 16'h0100;

    typedef enum logic [1:0] {
        ARB_FIXED,
        ARB_RR,
        ARB_PRIO,
        ARB_RSVD
    } arb_mode_t;

endpackage

// File: rtl/train_data_arbiter_rr_arbiter.sv
// Combinational grant selection for the training-data arbiter.
// Ports: req, mode, sel, ptr in; granted, grant out.
import gdo::*;

module rr_arbiter #(
    parameter int channels = 2,
    localparam int cw = $clog2(channels)
) (
    input  logic [channels-1:0] req,
    input  arb_mode_t           mode,
    input  logic [cw-1:0]       sel,
    input  logic [cw-1:0]       ptr,
    output logic                granted,
    output logic [cw-1:0]       grant
);

    always_comb begin
        int j;
        j       = 0;
        granted = 1'b0;
        grant   = '0;
        unique case (mode)
            ARB_FIXED: begin
                // An out-of-range sel matches no channel.
                for (int i = 0; i < channels; i++) begin
                    if (i == int'(sel) && req[i]) begin
                        granted = 1'b1;
                        grant   = cw'(i);
                    end
                end
            end
            ARB_PRIO: begin
                // Downward scan: the last hit is the lowest index.
                for (int i = channels - 1; i >= 0; i--) begin
                    if (req[i]) begin
                        granted = 1'b1;
                        grant   = cw'(i);
                    end
                end
            end
            ARB_RR: begin
                // Downward over offsets so the nearest one to ptr wins.
                for (int k = channels - 1; k >= 0; k--) begin
                    j = int'(ptr) + k;
                    if (j >= channels) j = j - channels;
                    if (req[j]) begin
                        granted = 1'b1;
                        grant   = cw'(j);
                    end
                end
            end
            ARB_RSVD: begin
                granted = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/train_data_arbiter.sv
// Arbitrates sample sources into one registered output stage.
// Ports: clk, rst_n, mode, sel, in_* handshake, out_* handshake, xfer_count.
import gdo::*;

module train_data_arbiter #(
    parameter int data_size = 16,
    parameter int size      = 3,
    parameter int channels  = 2,
    parameter bit bias_en   = 1'b1,
    localparam int cw = $clog2(channels),
    localparam int vw = data_size * size
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [cw-1:0]          sel,
    input  logic [channels-1:0]    in_valid,
    output logic [channels-1:0]    in_ready,
    input  logic [channels*vw-1:0] in_data,
    input  logic [channels*vw-1:0] in_predict,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [vw-1:0]          out_data,
    output logic [vw-1:0]          out_predict,
    output logic [cw-1:0]          out_channel,
    output logic [15:0]            xfer_count
);

    arb_mode_t     arb_mode;
    logic [cw-1:0] rr_ptr;
    logic [cw-1:0] grant;
    logic          granted;
    logic          load;
    logic          src_xfer;
    logic          out_xfer;
    logic [vw-1:0] cap_data;
    logic [vw-1:0] cap_pred;

    assign arb_mode = arb_mode_t'(mode);

    rr_arbiter #(
        .channels(channels)
    ) u_arb (
        .req     (in_valid),
        .mode    (arb_mode),
        .sel     (sel),
        .ptr     (rr_ptr),
        .granted (granted),
        .grant   (grant)
    );

    assign load     = !out_valid || out_ready;
    assign src_xfer = |(in_valid & in_ready);
    assign out_xfer = out_valid && out_ready;

    // rst_n gating keeps sources from seeing ready while held in reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && load && granted) in_ready[grant] = 1'b1;
    end

    always_comb begin
        cap_data = in_data[int'(grant)*vw +: vw];
        cap_pred = in_predict[int'(grant)*vw +: vw];
        if (bias_en) cap_data[data_size-1:0] = data_size'(gdo_one);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_predict <= '0;
            out_channel <= '0;
        end else begin
            out_valid <= src_xfer || (out_valid && !out_ready);
            if (src_xfer) begin
                out_data    <= cap_data;
                out_predict <= cap_pred;
                out_channel <= grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (src_xfer && arb_mode == ARB_RR) begin
            rr_ptr <= (int'(grant) == channels - 1) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (out_xfer) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end

endmodule
